uflash_ctrl: RTL and testbench

//  Parametrised user-flash bus controller between the CPU memory bus and an external flash macro controller.

---
 rtl/uflash_ctrl_pkg.sv | 24 ++
 rtl/uflash_ctrl_if.sv | 28 ++
 rtl/uflash_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uflash_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uflash_ctrl_pkg.sv
// Shared types and constants for the user-flash bus controller.
// State encoding, bus strobe command codes and the fill value returned on timeout.
// Imported by the controller top and by anything that decodes its commands.
package uflash_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_PROG,
    OP_ERASE
  } op_t;

  localparam logic [3:0]  WSTRB_READ   = 4'b0000;
  localparam logic [3:0]  WSTRB_PROG   = 4'b1111;
  localparam logic [3:0]  WSTRB_ERASE  = 4'b0001;
  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/uflash_ctrl_if.sv
// CPU-side memory bus of the user-flash controller.
// master = CPU / address decoder side, slave = uflash_ctrl.
// sel is held by the master until the one-cycle ready pulse.
interface uflash_ctrl_if #(
  parameter int ROW_BITS = 9,
  parameter int COL_BITS = 6
);
  localparam int AW = ROW_BITS + COL_BITS;

  logic          sel;
  logic [3:0]    wstrb;
  logic [AW-1:0] addr;
  logic [31:0]   data_i;
  logic          err_clr;
  logic          ready;
  logic [31:0]   data_o;
  logic          err;

  modport master (
    output sel, wstrb, addr, data_i, err_clr,
    input  ready, data_o, err
  );

  modport slave (
    input  sel, wstrb, addr, data_i, err_clr,
    output ready, data_o, err
  );
endinterface

// File: rtl/uflash_ctrl.sv
// User-flash bus controller: one-word read cache, page write protect, timeout, sticky err.
// Latency: cache hit / rejected request ready 1 cycle after accept; flash ops ready 1 cycle after fc_done.
// Backpressure: sel is held until ready; no new request is taken until the FSM is back in IDLE.
module uflash_ctrl
  import uflash_ctrl_pkg::*;
#(
  parameter int ROW_BITS      = 9,
  parameter int COL_BITS      = 6,
  parameter int ROWS_PER_PAGE = 8,
  parameter int PROT_PAGE     = 32,
  parameter int TIMEOUT       = 65535,
  parameter int CACHE_EN      = 1
) (
  input  logic                clk,
  input  logic                reset,
  uflash_ctrl_if.slave        bus,
  output logic                fc_start,
  output logic                fc_wr_en,
  output logic                fc_erase,
  output logic [ROW_BITS-1:0] fc_xaddr,
  output logic [COL_BITS-1:0] fc_yaddr,
  output logic [31:0]         fc_wdata,
  input  logic [31:0]         fc_rdata,
  input  logic                fc_done
);

  localparam int AW         = ROW_BITS + COL_BITS;
  localparam int PAGE_SHIFT = $clog2(ROWS_PER_PAGE);
  localparam int CW         = $clog2(TIMEOUT + 1);
  // The abort fires on the WAIT cycle in which the counter would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  function automatic logic [31:0] page_of(input logic [ROW_BITS-1:0] row);
    return 32'(row) >> PAGE_SHIFT;
  endfunction

  state_t        state;
  op_t           op;
  logic [CW-1:0] cnt;
  logic          ready_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic          cache_vld;
  logic [AW-1:0] cache_tag;
  logic [31:0]   cache_dat;

  logic [ROW_BITS-1:0] req_row;
  logic                is_read, is_prog, is_erase, illegal, prot, hit;
  logic                accept, reject, done_evt, timeout_evt, err_set;
  logic                inv_on_done;

  assign req_row = bus.addr[AW-1:COL_BITS];

  // Request decode and completion/error event detection.
  always_comb begin
    is_read     = (bus.wstrb == WSTRB_READ);
    is_prog     = (bus.wstrb == WSTRB_PROG);
    is_erase    = (bus.wstrb == WSTRB_ERASE);
    illegal     = !(is_read || is_prog || is_erase);
    prot        = (is_prog || is_erase) && (page_of(req_row) >= 32'(PROT_PAGE));
    hit         = (CACHE_EN != 0) && is_read && cache_vld && (cache_tag == bus.addr);
    accept      = (state == ST_IDLE) && bus.sel;
    reject      = illegal || prot;
    done_evt    = (state == ST_WAIT) && fc_done;
    timeout_evt = (state == ST_WAIT) && !fc_done && (cnt == CNT_LAST);
    err_set     = (accept && reject) || timeout_evt;
    // A completed program to the cached word, or an erase of its page, makes the cache stale.
    inv_on_done = ((op == OP_PROG) && (cache_tag == {fc_xaddr, fc_yaddr})) ||
                  ((op == OP_ERASE) &&
                   (page_of(cache_tag[AW-1:COL_BITS]) == page_of(fc_xaddr)));
  end

  // Main FSM with registered flash-command, bus-response and cache state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op        <= OP_READ;
      cnt       <= '0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      fc_start  <= 1'b0;
      fc_wr_en  <= 1'b0;
      fc_erase  <= 1'b0;
      fc_xaddr  <= '0;
      fc_yaddr  <= '0;
      fc_wdata  <= '0;
      cache_vld <= 1'b0;
      cache_tag <= '0;
      cache_dat <= '0;
    end else begin
      fc_start <= 1'b0;
      ready_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.sel) begin
            fc_xaddr <= req_row;
            fc_yaddr <= bus.addr[COL_BITS-1:0];
            fc_wdata <= bus.data_i;
            data_q   <= '0;
            if (reject) begin
              ready_q <= 1'b1;
              state   <= ST_DONE;
            end else if (hit) begin
              data_q  <= cache_dat;
              ready_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              op       <= is_prog ? OP_PROG : (is_erase ? OP_ERASE : OP_READ);
              fc_wr_en <= is_prog;
              fc_erase <= is_erase;
              fc_start <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done_evt) begin
            if (op == OP_READ) begin
              data_q    <= fc_rdata;
              cache_vld <= (CACHE_EN != 0);
              cache_tag <= {fc_xaddr, fc_yaddr};
              cache_dat <= fc_rdata;
            end else if (inv_on_done) begin
              cache_vld <= 1'b0;
            end
            ready_q <= 1'b1;
            state   <= ST_DONE;
          end else if (timeout_evt) begin
            // The flash state is unknown after an aborted write, so drop the cache.
            if (op != OP_READ) cache_vld <= 1'b0;
            data_q  <= TIMEOUT_FILL;
            ready_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          fc_wr_en <= 1'b0;
          fc_erase <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            err_q <= 1'b0;
    else if (err_set)     err_q <= 1'b1;
    else if (bus.err_clr) err_q <= 1'b0;
  end

  assign bus.ready  = ready_q;
  assign bus.data_o = data_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_uflash_ctrl.sv
// Directed bench for uflash_ctrl with a behavioural flash responder and a response scoreboard.
// Each request pushes its expected response; a monitor pops and checks it when ready pulses.
// Flash responder answers fc_start after a programmable number of cycles (negative = never).
module tb_uflash_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] data;
    bit          chk;
    logic        err;
    int          starts;
    int          lat;
    logic [1:0]  cmd;
    logic [14:0] addr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        fc_start, fc_wr_en, fc_erase;
  logic [8:0]  fc_xaddr;
  logic [5:0]  fc_yaddr;
  logic [31:0] fc_wdata, fc_rdata;
  logic        fc_done;

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  exp_t        me;
  int          flash_delay = -1;
  logic [31:0] flash_val = '0;
  int          mon_starts, mon_lat;
  logic [1:0]  cap_cmd;
  logic [14:0] cap_addr;

  uflash_ctrl_if #(.ROW_BITS(9), .COL_BITS(6)) bus ();

  uflash_ctrl #(
    .ROW_BITS(9), .COL_BITS(6), .ROWS_PER_PAGE(8),
    .PROT_PAGE(32), .TIMEOUT(16), .CACHE_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fc_start(fc_start), .fc_wr_en(fc_wr_en), .fc_erase(fc_erase),
    .fc_xaddr(fc_xaddr), .fc_yaddr(fc_yaddr), .fc_wdata(fc_wdata),
    .fc_rdata(fc_rdata), .fc_done(fc_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Flash responder: answers each fc_start with one fc_done pulse carrying flash_val.
  initial begin
    fc_done  = 1'b0;
    fc_rdata = '0;
    forever begin
      @(negedge clk);
      if (fc_start && !reset && flash_delay > 0) begin
        repeat (flash_delay) @(negedge clk);
        #1;
        fc_rdata = flash_val;
        fc_done  = 1'b1;
        @(negedge clk);
        #1 fc_done = 1'b0;
      end
    end
  end

  // Monitor: counts fc_start pulses and request cycles, checks each ready against the queue.
  initial begin
    mon_starts = 0;
    mon_lat    = 0;
    cap_cmd    = '0;
    cap_addr   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_starts = 0;
        mon_lat    = 0;
      end else begin
        if (fc_start) begin
          mon_starts++;
          cap_cmd  = {fc_wr_en, fc_erase};
          cap_addr = {fc_xaddr, fc_yaddr};
        end
        if (bus.sel) mon_lat++;
        if (bus.ready) begin
          tests++;
          assert (q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_ready: observed ready with empty queue, expected no ready");
          end
          if (q.size() > 0) begin
            me = q.pop_front();
            check({me.tag, "_err"}, 32'(bus.err), 32'(me.err));
            check({me.tag, "_starts"}, 32'(mon_starts), 32'(me.starts));
            if (me.chk) check({me.tag, "_data"}, bus.data_o, me.data);
            if (me.lat >= 0) check({me.tag, "_latency"}, 32'(mon_lat), 32'(me.lat));
            if (me.starts > 0) begin
              check({me.tag, "_cmd"}, 32'(cap_cmd), 32'(me.cmd));
              check({me.tag, "_addr"}, 32'(cap_addr), 32'(me.addr));
            end
          end
          mon_starts = 0;
          mon_lat    = 0;
        end
      end
    end
  end

  task automatic do_op(input string tag, input logic [3:0] ws, input logic [14:0] a,
                       input logic [31:0] d, input int fdelay, input logic [31:0] fval,
                       input logic [31:0] edata, input bit chk, input logic eerr,
                       input int estarts, input int elat);
    exp_t e;
    bit   got;
    e.tag    = tag;
    e.data   = edata;
    e.chk    = chk;
    e.err    = eerr;
    e.starts = estarts;
    e.lat    = elat;
    e.cmd    = {ws == 4'b1111, ws == 4'b0001};
    e.addr   = a;
    @(negedge clk);
    #1;
    flash_delay = fdelay;
    flash_val   = fval;
    q.push_back(e);
    bus.sel    = 1'b1;
    bus.wstrb  = ws;
    bus.addr   = a;
    bus.data_i = d;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    bus.sel   = 1'b0;
    bus.wstrb = '0;
    tests++;
    assert (got) else begin
      fails++;
      $error("FAIL %s_wait: observed no ready within 100 cycles, expected ready", tag);
      if (q.size() > 0) void'(q.pop_front());
    end
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(bus.ready), 32'd0);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clk);
    #1 bus.err_clr = 1'b1;
    @(negedge clk);
    #1 bus.err_clr = 1'b0;
    check({tag, "_err_cleared"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.sel     = 1'b0;
    bus.wstrb   = '0;
    bus.addr    = '0;
    bus.data_i  = '0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
    check("rst_fc_start", 32'(fc_start), 32'd0);
    check("rst_fc_cmd", 32'({fc_wr_en, fc_erase}), 32'd0);
    check("rst_fc_addr", 32'({fc_xaddr, fc_yaddr}), 32'd0);
    #1 reset = 1'b0;

    // Read miss, then hit, then program invalidates the cached word.
    do_op("rd_miss", 4'b0000, 15'h0041, 32'h0, 10, 32'h1234_5678, 32'h1234_5678, 1, 0, 1, -1);
    do_op("rd_hit", 4'b0000, 15'h0041, 32'h0, 10, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 0, 1);
    do_op("prog", 4'b1111, 15'h0041, 32'hA5A5_0001, 5, 32'h0, 32'h0, 0, 0, 1, -1);
    check("prog_wdata", fc_wdata, 32'hA5A5_0001);
    do_op("rd_after_prog", 4'b0000, 15'h0041, 32'h0, 4, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 1, -1);
    do_op("rd_hit2", 4'b0000, 15'h0041, 32'h0, 4, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0, 0, 1);
    // Erase of page 0 (rows 0..7) invalidates the cached word in row 1.
    do_op("erase_pg0", 4'b0001, 15'h0000, 32'h0, 3, 32'h0, 32'h0, 0, 0, 1, -1);
    do_op("rd_after_erase", 4'b0000, 15'h0041, 32'h0, 6, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0, 1, -1);
    // Last unprotected page is writable.
    do_op("prog_pg31", 4'b1111, 15'h3FC0, 32'h0000_0001, 3, 32'h0, 32'h0, 0, 0, 1, -1);

    // Protected page: rejected without touching flash.
    do_op("erase_prot", 4'b0001, 15'h4000, 32'h0, -1, 32'h0, 32'h0, 1, 1, 0, 1);
    clear_err("erase_prot");
    do_op("prog_prot", 4'b1111, 15'h7FFF, 32'h5555_AAAA, -1, 32'h0, 32'h0, 1, 1, 0, 1);
    clear_err("prog_prot");

    // Read that never completes: aborted after TIMEOUT wait cycles.
    do_op("rd_timeout", 4'b0000, 15'h0100, 32'h0, -1, 32'h0, 32'hFFFF_FFFF, 1, 1, 1, 18);
    clear_err("rd_timeout");

    // Illegal strobe, then reset in the middle of a program.
    do_op("illegal", 4'b0011, 15'h0041, 32'h0, -1, 32'h0, 32'h0, 1, 1, 0, 1);
    @(negedge clk);
    #1;
    flash_delay = -1;
    bus.sel     = 1'b1;
    bus.wstrb   = 4'b1111;
    bus.addr    = 15'h0041;
    bus.data_i  = 32'h1111_2222;
    repeat (5) @(negedge clk);
    check("abort_wr_en_before", 32'(fc_wr_en), 32'd1);
    #1;
    reset   = 1'b1;
    bus.sel = 1'b0;
    #1;
    check("abort_wr_en", 32'(fc_wr_en), 32'd0);
    check("abort_fc_start", 32'(fc_start), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_fc_addr", 32'({fc_xaddr, fc_yaddr}), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ready", 32'(bus.ready), 32'd0);
    do_op("rd_after_reset", 4'b0000, 15'h0041, 32'h0, 5, 32'h600D_CAFE, 32'h600D_CAFE, 1, 0, 1, -1);

    // Clear held across a timeout: the error still lands.
    @(negedge clk);
    #1 bus.err_clr = 1'b1;
    do_op("rd_timeout_clr", 4'b0000, 15'h0200, 32'h0, -1, 32'h0, 32'hFFFF_FFFF, 1, 1, 1, 18);
    #1 bus.err_clr = 1'b0;
    @(negedge clk);
    check("timeout_clr_after", 32'(bus.err), 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
